row_feeder: RTL

ROW_FEEDER -- requirements
Module: row_feeder

---
 rtl/chip_pkg.sv | 14 +
 rtl/row_buf.sv | 38 +++
 rtl/row_feeder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/chip_pkg.sv
// Shared types and constants for the row feeder: FSM encoding, pixel width, window height.
package chip_pkg;

  localparam int unsigned PixW = 5;
  localparam int unsigned WinH = 5;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StStream,
    StDone
  } state_e;

endpackage

// File: rtl/row_buf.sv
// One image row of pixels, written and read at a single column per cycle.
// With ROW_FEEDER_PAD_EN defined, a clr input zeroes the whole row.
module row_buf
  import chip_pkg::*;
#(
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
`ifdef ROW_FEEDER_PAD_EN
  input  logic             clr,
`endif
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic [PixW-1:0]  wdata,
  output logic [PixW-1:0]  rdata
);

  logic [PixW-1:0] mem [Depth];

`ifdef ROW_FEEDER_PAD_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(Depth); i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
`endif

  // Read is combinational so the old column is shifted up in the same cycle it is rewritten.
  assign rdata = mem[addr];

endmodule

// File: rtl/row_feeder.sv
// Row feeder: keeps the last four raster rows and emits 5-pixel vertical columns.
// Define ROW_FEEDER_PAD_EN to zero the rows on start and stream from row 0.
module row_feeder
  import chip_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            pix_valid,
  input  logic [PixW-1:0] pix_in,
  output logic            pix_ready,
  output logic [PixW-1:0] pixel_out0,
  output logic [PixW-1:0] pixel_out1,
  output logic [PixW-1:0] pixel_out2,
  output logic [PixW-1:0] pixel_out3,
  output logic [PixW-1:0] pixel_out4,
  output logic            out_valid,
  output logic            load_end
);

  localparam int ColW = $clog2(IMG_W);
  localparam int RowW = $clog2(IMG_H);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);
  localparam logic [RowW-1:0] RowFillLast = RowW'(WinH - 2);
`ifdef ROW_FEEDER_PAD_EN
  localparam state_e StFirst = StStream;
`else
  localparam state_e StFirst = StFill;
`endif

  state_e state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic accept, emit, col_last, row_last;
  logic [PixW-1:0] rd_data [WinH-1];
  logic [PixW-1:0] wr_data [WinH-1];

  assign pix_ready = (state_q == StFill) || (state_q == StStream);
  assign accept    = pix_valid && pix_ready;
  assign emit      = accept && (state_q == StStream);
  assign col_last  = (col_q == ColLast);
  assign row_last  = (row_q == RowLast);

`ifdef ROW_FEEDER_PAD_EN
  logic clr;
  assign clr = (state_q == StIdle) && start;
`endif

  // Each buffer takes the row below it; the newest row comes straight from pix_in.
  assign wr_data[0] = rd_data[1];
  assign wr_data[1] = rd_data[2];
  assign wr_data[2] = rd_data[3];
  assign wr_data[3] = pix_in;

  for (genvar i = 0; i < WinH - 1; i++) begin : g_buf
    row_buf #(
      .Depth (IMG_W)
    ) u_row_buf (
      .clk   (clk),
`ifdef ROW_FEEDER_PAD_EN
      .clr   (clr),
`endif
      .we    (accept),
      .addr  (col_q),
      .wdata (wr_data[i]),
      .rdata (rd_data[i])
    );
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFirst;
          col_d   = '0;
          row_d   = '0;
        end
      end
      StFill:   if (accept && col_last && row_q == RowFillLast) state_d = StStream;
      StStream: if (accept && col_last && row_last) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (accept) begin
      col_d = col_last ? '0 : col_q + 1'b1;
      if (col_last) row_d = row_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      out_valid  <= 1'b0;
      load_end   <= 1'b0;
      pixel_out0 <= '0;
      pixel_out1 <= '0;
      pixel_out2 <= '0;
      pixel_out3 <= '0;
      pixel_out4 <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      out_valid <= emit;
      load_end  <= emit && col_last && row_last;
      if (emit) begin
        pixel_out0 <= rd_data[0];
        pixel_out1 <= rd_data[1];
        pixel_out2 <= rd_data[2];
        pixel_out3 <= rd_data[3];
        pixel_out4 <= pix_in;
      end
    end
  end

endmodule
